// File: rtl/oc_mem_stream_loader.sv
// Byte-stream loader for the CPU's 32-bit on-chip memory: packs bytes little-endian into
// words and writes them to consecutive word addresses, reporting count, completion and overflow.
module oc_mem_stream_loader #(
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PACK  = 3'd1,
        S_WRITE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        lane;
    logic [31:0]       pack_buf;
    logic [31:0]       packed_word;
    logic              last_seen;
    logic              wr_now;

    // Stream handshake: a byte transfers on any rising edge where s_valid && s_ready;
    // s_ready depends only on state, and s_data/s_last are meaningful only with s_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_PACK;
            end
            S_PACK: begin
                s_ready = 1'b1;
                if (s_valid && (lane == 3'd3 || s_last)) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (last_seen)              state_nxt = S_DONE;
                else if (addr == LAST_ADDR) state_nxt = S_DRAIN;
                else                        state_nxt = S_PACK;
            end
            S_DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_comb begin
        packed_word = pack_buf;
        packed_word[{lane[1:0], 3'b000} +: 8] = s_data;
    end

    // An abort landing on the write cycle suppresses that write.
    assign wr_now         = (state == S_WRITE) && !abort;
    assign mem_write      = wr_now;
    assign mem_chipselect = wr_now;
    assign mem_address    = addr;
    assign busy           = (state == S_PACK) || (state == S_WRITE) || (state == S_DRAIN);
    assign dbg_state      = state;

    always_comb begin
        mem_byteenable = 4'b0000;
        if (wr_now) begin
            case (lane)
                3'd1:    mem_byteenable = 4'b0001;
                3'd2:    mem_byteenable = 4'b0011;
                3'd3:    mem_byteenable = 4'b0111;
                default: mem_byteenable = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr          <= BASE;
            lane          <= 3'd0;
            pack_buf      <= 32'd0;
            last_seen     <= 1'b0;
            mem_writedata <= 32'd0;
            word_count    <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
        end else if (abort) begin
            lane      <= 3'd0;
            pack_buf  <= 32'd0;
            last_seen <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr       <= BASE;
                        lane       <= 3'd0;
                        pack_buf   <= 32'd0;
                        last_seen  <= 1'b0;
                        word_count <= '0;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
                    end
                end
                S_PACK: begin
                    if (s_valid) begin
                        pack_buf <= packed_word;
                        lane     <= lane + 3'd1;
                        if (lane == 3'd3 || s_last) begin
                            mem_writedata <= packed_word;
                            last_seen     <= s_last;
                        end
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + 1'b1;
                    lane       <= 3'd0;
                    pack_buf   <= 32'd0;
                    if (last_seen)              done     <= 1'b1;
                    else if (addr == LAST_ADDR) overflow <= 1'b1;
                    else                        addr     <= addr + 1'b1;
                end
                S_DRAIN: begin
                    if (s_valid && s_last) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
